// File: rtl/spdif_frame_reader_pkg.sv
// Shared types and constants for the S/PDIF frame reader.
// Contents: preamble codes, subframe payload layout, block length,
// FSM state encoding and the even-parity helper.
package spdif_frame_reader_pkg;

    localparam int unsigned AUDIO_W          = 24;
    localparam int unsigned PAYLOAD_W        = 28;
    localparam int unsigned IDX_W            = 8;
    localparam int unsigned FRAMES_PER_BLOCK = 192;
    localparam int unsigned CS_BITS          = 32;
    localparam int unsigned CS_SEL_W         = 5;

    // Preamble codes presented to the biphase-mark serializer.
    localparam logic [1:0] PRE_B = 2'd0;
    localparam logic [1:0] PRE_M = 2'd1;
    localparam logic [1:0] PRE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_t;

    // Subframe bits 4..31; member order puts audio in [23:0] and P in [27].
    typedef struct packed {
        logic               p;
        logic               c;
        logic               u;
        logic               v;
        logic [AUDIO_W-1:0] audio;
    } payload_t;

    // Even parity over audio, V, U and C (subframe bits 4..30).
    function automatic logic even_parity(input payload_t pl);
        return ^{pl.audio, pl.v, pl.u, pl.c};
    endfunction

endpackage

// File: rtl/spdif_frame_reader_if.sv
// FIFO read port and subframe handshake bundle.
// master: frame reader (pops FIFO, offers subframes)
// slave : FIFO + serializer side (supplies head words, accepts subframes)
//   fifo_empty/fifo_left/fifo_right : first-word-fall-through FIFO head
//   fifo_read_en                    : pop strobe
//   sub_valid/sub_ready             : subframe handshake
//   sub_preamble/sub_payload        : subframe contents
interface spdif_frame_reader_if
    import spdif_frame_reader_pkg::*;
#(
    parameter int unsigned WORDSIZE = 32
) ();

    logic                fifo_empty;
    logic [WORDSIZE-1:0] fifo_left;
    logic [WORDSIZE-1:0] fifo_right;
    logic                fifo_read_en;
    logic                sub_valid;
    logic                sub_ready;
    logic [1:0]          sub_preamble;
    payload_t            sub_payload;

    modport master (
        input  fifo_empty, fifo_left, fifo_right, sub_ready,
        output fifo_read_en, sub_valid, sub_preamble, sub_payload
    );

    modport slave (
        output fifo_empty, fifo_left, fifo_right, sub_ready,
        input  fifo_read_en, sub_valid, sub_preamble, sub_payload
    );

endinterface

// File: rtl/spdif_frame_reader_subframe_pack.sv
// Combinational subframe formatter: picks the preamble and builds the
// 28-bit payload (audio, V, U=0, C, even parity) from one latched sample.
//   sample      : latched FIFO word, audio taken from the top 24 bits
//   v, c        : validity and channel-status bit for this frame
//   is_right    : right-channel subframe (W preamble)
//   first_frame : frame 0 of the channel-status block (B preamble)
//   preamble_c  : preamble code
//   payload_c   : subframe bits 4..31
module spdif_frame_reader_subframe_pack
    import spdif_frame_reader_pkg::*;
#(
    parameter int unsigned WORDSIZE = 32
) (
    input  logic [WORDSIZE-1:0] sample,
    input  logic                v,
    input  logic                c,
    input  logic                is_right,
    input  logic                first_frame,
    output logic [1:0]          preamble_c,
    output payload_t            payload_c
);

    // Sample LSBs below the 24 audio bits are intentionally dropped.
    logic unused_sample_bits;
    assign unused_sample_bits = ^sample;

    payload_t fields;

    always_comb begin
        fields       = '0;
        fields.audio = sample[WORDSIZE-1 -: AUDIO_W];
        fields.v     = v;
        fields.u     = 1'b0;
        fields.c     = c;
        fields.p     = 1'b0;
        payload_c    = fields;
        payload_c.p  = even_parity(fields);
    end

    always_comb begin
        preamble_c = PRE_M;
        if (is_right) begin
            preamble_c = PRE_W;
        end else if (first_frame) begin
            preamble_c = PRE_B;
        end
    end

endmodule

// File: rtl/spdif_frame_reader.sv
// Read side of the stereo sample FIFO: pops one L/R pair per S/PDIF frame,
// formats it into two subframes and hands them to the serializer.
// Tracks the 192-frame channel-status block and substitutes a silent,
// invalid frame (V=1) when the FIFO is empty so the stream never stalls.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   enable    : run request; a frame in progress always completes
//   bus       : FIFO read port and subframe handshake (master side)
//   frame_idx : frame number within the channel-status block, 0..191
//   underrun  : one-cycle pulse when a frame is loaded without FIFO data
module spdif_frame_reader
    import spdif_frame_reader_pkg::*;
#(
    parameter int unsigned          WORDSIZE = 32,
    parameter logic [CS_BITS-1:0]   CS_LOW   = 32'h0200_0004
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    spdif_frame_reader_if.master    bus,
    output logic [IDX_W-1:0]        frame_idx,
    output logic                    underrun
);

    state_t              state;
    state_t              state_next;
    logic [WORDSIZE-1:0] left_q;
    logic [WORDSIZE-1:0] right_q;
    logic                v_q;

    logic                load_c;
    logic                pop_c;
    logic                active_c;
    logic                is_right_c;
    logic                accept_c;
    logic                cs_bit_c;
    logic [1:0]          preamble_c;
    payload_t            payload_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        active_c   = 1'b0;
        is_right_c = 1'b0;
        accept_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_c     = 1'b1;
                state_next = ST_LEFT;
            end
            ST_LEFT: begin
                active_c = 1'b1;
                if (bus.sub_ready) begin
                    state_next = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                active_c   = 1'b1;
                is_right_c = 1'b1;
                if (bus.sub_ready) begin
                    accept_c   = 1'b1;
                    state_next = enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pop only in LOAD with data available; otherwise flag the underrun.
    assign pop_c            = load_c & ~bus.fifo_empty;
    assign underrun         = load_c &  bus.fifo_empty;
    assign bus.fifo_read_en = pop_c;
    assign bus.sub_valid    = active_c;

    // Sample pair and validity latch; an empty FIFO yields silence with V=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q  <= '0;
            right_q <= '0;
            v_q     <= 1'b0;
        end else if (load_c) begin
            if (pop_c) begin
                left_q  <= bus.fifo_left;
                right_q <= bus.fifo_right;
                v_q     <= 1'b0;
            end else begin
                left_q  <= '0;
                right_q <= '0;
                v_q     <= 1'b1;
            end
        end
    end

    // Block frame counter, advanced when the right subframe is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_idx <= '0;
        end else if (accept_c) begin
            if (frame_idx == IDX_W'(FRAMES_PER_BLOCK - 1)) begin
                frame_idx <= '0;
            end else begin
                frame_idx <= frame_idx + IDX_W'(1);
            end
        end
    end

    // Channel-status bit: only the first 32 bits of the block are non-zero.
    always_comb begin
        cs_bit_c = 1'b0;
        if (frame_idx < IDX_W'(CS_BITS)) begin
            cs_bit_c = CS_LOW[frame_idx[CS_SEL_W-1:0]];
        end
    end

    spdif_frame_reader_subframe_pack #(
        .WORDSIZE (WORDSIZE)
    ) u_pack (
        .sample      (is_right_c ? right_q : left_q),
        .v           (v_q),
        .c           (cs_bit_c),
        .is_right    (is_right_c),
        .first_frame (frame_idx == '0),
        .preamble_c  (preamble_c),
        .payload_c   (payload_c)
    );

    // Subframe fields read as zero whenever no subframe is offered.
    assign bus.sub_preamble = active_c ? preamble_c : 2'b00;
    assign bus.sub_payload  = active_c ? payload_c  : '0;

endmodule

// File: tb/tb_spdif_frame_reader.sv
// Self-checking bench for spdif_frame_reader: a frame-level reference model
// (pending subframes, block counter, FIFO queue) predicts every output each
// cycle; directed steps cover start-up, block wrap, underrun, back-pressure,
// enable drop and asynchronous reset, followed by a randomized phase.
module tb_spdif_frame_reader;

    localparam logic [31:0] CS = 32'h0200_0004;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] frame_idx;
    logic       underrun;

    always #5 clk = ~clk;

    spdif_frame_reader_if #(.WORDSIZE(32)) bus ();

    spdif_frame_reader #(
        .WORDSIZE (32),
        .CS_LOW   (CS)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .enable    (enable),
        .bus       (bus),
        .frame_idx (frame_idx),
        .underrun  (underrun)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] fifo_q[$];

    // Reference model: a frame is loaded, then two subframes are pending.
    bit          m_load;
    int          m_pend;
    int          m_idx;
    logic [23:0] m_l;
    logic [23:0] m_r;
    logic        m_v;

    int          frames_done = 0;
    int          pops        = 0;
    int          underruns   = 0;
    int          b_count     = 0;
    logic [27:0] last_left;
    logic [27:0] last_right;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] exp_payload(input logic [23:0] audio, input logic v, input int idx);
        logic c;
        c = 1'b0;
        if (idx < 32) c = CS[idx];
        return {^{audio, v, c}, c, 1'b0, v, audio};
    endfunction

    // One clock cycle: drive at the negedge, check 1 ns later, step the model.
    task automatic tick(input logic en, input logic rdy);
        bit          empty_now;
        logic [27:0] exp_pl;
        logic [1:0]  exp_pre;
        enable        = en;
        bus.sub_ready = rdy;
        empty_now     = (fifo_q.size() == 0);
        bus.fifo_empty = empty_now;
        if (!empty_now) begin
            bus.fifo_left  = fifo_q[0][63:32];
            bus.fifo_right = fifo_q[0][31:0];
        end else begin
            bus.fifo_left  = $urandom;
            bus.fifo_right = $urandom;
        end
        #1;
        chk("fifo_read_en", 32'(bus.fifo_read_en), 32'(m_load && !empty_now));
        chk("underrun", 32'(underrun), 32'(m_load && empty_now));
        chk("sub_valid", 32'(bus.sub_valid), 32'(m_pend != 0));
        chk("frame_idx", 32'(frame_idx), 32'(m_idx));
        if (m_pend != 0) begin
            exp_pl  = exp_payload((m_pend == 2) ? m_l : m_r, m_v, m_idx);
            exp_pre = (m_pend == 1) ? 2'd2 : ((m_idx == 0) ? 2'd0 : 2'd1);
            chk("sub_preamble", 32'(bus.sub_preamble), 32'(exp_pre));
            chk("sub_payload", 32'(bus.sub_payload), 32'(exp_pl));
            if (rdy) begin
                if (m_pend == 2) begin
                    last_left = bus.sub_payload;
                    if (bus.sub_preamble == 2'd0) b_count++;
                end else begin
                    last_right = bus.sub_payload;
                end
            end
        end
        if (bus.fifo_read_en === 1'b1) pops++;
        if (underrun === 1'b1) underruns++;
        if (m_load) begin
            if (!empty_now) begin
                m_l = fifo_q[0][63:40];
                m_r = fifo_q[0][31:8];
                m_v = 1'b0;
            end else begin
                m_l = '0;
                m_r = '0;
                m_v = 1'b1;
            end
            m_pend = 2;
            m_load = 1'b0;
        end else if (m_pend != 0) begin
            if (rdy) begin
                m_pend--;
                if (m_pend == 0) begin
                    frames_done++;
                    m_idx  = (m_idx + 1) % 192;
                    m_load = en;
                end
            end
        end else begin
            m_load = en;
        end
        if (bus.fifo_read_en === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run_frames(input int n, input int budget);
        int target;
        int c;
        target = frames_done + n;
        c = 0;
        while (frames_done < target && c < budget) begin
            tick(1'b1, 1'b1);
            c++;
        end
        chk("frame_budget", 32'(frames_done >= target), 32'd1);
    endtask

    // Let any frame in progress finish with enable low.
    task automatic idle_out();
        int n;
        n = 0;
        while ((m_pend != 0 || m_load) && n < 50) begin
            tick(1'b0, 1'b1);
            n++;
        end
        chk("drain", 32'(m_pend == 0 && !m_load), 32'd1);
    endtask

    task automatic model_reset();
        m_load = 1'b0;
        m_pend = 0;
        m_idx  = 0;
        m_l    = '0;
        m_r    = '0;
        m_v    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int u0;
        int b0;
        int idx0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        bus.sub_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_left  = '0;
        bus.fifo_right = '0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sub_valid", 32'(bus.sub_valid), 32'd0);
        chk("rst_preamble", 32'(bus.sub_preamble), 32'd0);
        chk("rst_payload", 32'(bus.sub_payload), 32'd0);
        chk("rst_frame_idx", 32'(frame_idx), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_read_en", 32'(bus.fifo_read_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame with known data.
        fifo_q.push_back({32'h1234_5600, 32'hABCD_EF00});
        p0 = pops;
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b1);
        chk("t1_pops", 32'(pops - p0), 32'd1);
        chk("t1_left", 32'(last_left), 32'h0812_3456);
        chk("t1_right", 32'(last_right), 32'h08AB_CDEF);
        chk("t1_frame_idx", 32'(frame_idx), 32'd1);

        // 193 continuous frames: crosses the 191 -> 0 wrap once.
        for (int i = 0; i < 193; i++) fifo_q.push_back({$urandom, $urandom});
        b0 = b_count;
        run_frames(193, 2000);
        idle_out();
        chk("t2_b_count", 32'(b_count - b0), 32'd1);

        // Underrun: empty FIFO still produces a frame.
        fifo_q.delete();
        u0 = underruns;
        p0 = pops;
        idx0 = m_idx;
        tick(1'b1, 1'b1);
        idle_out();
        chk("t3_underruns", 32'(underruns - u0), 32'd1);
        chk("t3_pops", 32'(pops - p0), 32'd0);
        chk("t3_idx_adv", 32'(frame_idx), 32'((idx0 + 1) % 192));

        // Back-pressure for 5 cycles on the left subframe.
        fifo_q.push_back({$urandom, $urandom});
        p0 = pops;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        idle_out();
        chk("t4_pops", 32'(pops - p0), 32'd1);

        // Enable dropped during LEFT, then restart continues the block.
        fifo_q.push_back({$urandom, $urandom});
        fifo_q.push_back({$urandom, $urandom});
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b1);
        idx0 = m_idx;
        tick(1'b1, 1'b1);
        idle_out();
        chk("t5_restart_idx", 32'(frame_idx), 32'((idx0 + 1) % 192));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) < 3 && fifo_q.size() < 4) fifo_q.push_back({$urandom, $urandom});
            tick(1'($urandom_range(9) != 0), 1'($urandom_range(3) != 0));
        end
        idle_out();

        // Asynchronous reset while the right subframe is pending.
        fifo_q.push_back({$urandom, $urandom});
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("t6_in_right", 32'(m_pend), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_sub_valid", 32'(bus.sub_valid), 32'd0);
        chk("t6_frame_idx", 32'(frame_idx), 32'd0);
        chk("t6_preamble", 32'(bus.sub_preamble), 32'd0);
        chk("t6_payload", 32'(bus.sub_payload), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q.delete();
        fifo_q.push_back({$urandom, $urandom});
        b0 = b_count;
        tick(1'b1, 1'b1);
        idle_out();
        chk("t6_first_b", 32'(b_count - b0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
